// File: rtl/aardvark_pkg.sv
// aardvark_pkg: shared control encodings for the aardvark multicycle core
package aardvark_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_NAND  = 3'b001;
  localparam logic [2:0] OP_SLT   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_MEM   = 3'b111;
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_MEM = 3'b111;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
endpackage

// File: rtl/ctrl_opdecode.sv
// ctrl_opdecode: maps the instruction register to ALUop and funct for the ALU control unit
module ctrl_opdecode
  import aardvark_pkg::*;
(
  input  logic [7:0] ir,
  output logic [2:0] alu_op,
  output logic       alu_funct
);
  logic [2:0] op;
  logic       unused_ir;
  assign op = ir[7:5];
  assign unused_ir = ^ir[4:1];
  // add/nand always take funct=1, addi funct=0; loads and stores use the address add
  always_comb begin
    alu_op = (op == OP_MEM) ? ALUOP_MEM : op;
    alu_funct = (op == OP_ADD || op == OP_NAND) ? 1'b1 : (op == OP_ADDI) ? 1'b0 : ir[0];
  end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle control FSM with retired-instruction counter
module main_control_fsm
  import aardvark_pkg::*;
#(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [7:0]          instr,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                mem_read,
  output logic                mem_write,
  output logic                addr_sel,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [2:0]          alu_op,
  output logic                alu_funct,
  output logic                alu_src_imm,
  output logic                reg_write,
  output logic                wb_sel,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);
  state_t     state, nxt;
  logic [7:0] ir;
  logic [2:0] op, dec_op;
  logic       f, dec_funct, retire;
  assign op = ir[7:5];
  assign f = ir[0];
  assign halted = state == S_HALT;
  ctrl_opdecode u_opdecode (
    .ir        (ir),
    .alu_op    (dec_op),
    .alu_funct (dec_funct)
  );
  // state, instruction register and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ir <= '0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (ir_load) ir <= instr;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end
  // next state and control strobes; reset masks everything so nothing fires while it is held
  always_comb begin
    nxt = state;
    mem_read = 1'b0;
    mem_write = 1'b0;
    addr_sel = 1'b0;
    ir_load = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_INC;
    alu_op = ALUOP_ADD;
    alu_funct = 1'b0;
    alu_src_imm = 1'b0;
    reg_write = 1'b0;
    wb_sel = 1'b0;
    retire = 1'b0;
    case (state)
      S_IDLE: nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_read = 1'b1;
        ir_load = mem_ready;
        pc_write = mem_ready;
        nxt = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        retire = op == OP_JMP;
        pc_write = op == OP_JMP && !f;
        pc_src = (op == OP_JMP && !f) ? PC_JMP : PC_INC;
        nxt = (op != OP_JMP) ? S_EXEC : f ? S_HALT : S_FETCH;
      end
      S_EXEC: begin
        alu_op = dec_op;
        alu_funct = dec_funct;
        alu_src_imm = op == OP_ADDI || op == OP_MEM;
        pc_write = op == OP_BEQ && alu_zero;
        pc_src = (op == OP_BEQ) ? PC_BR : PC_INC;
        retire = op == OP_BEQ;
        nxt = (op == OP_BEQ) ? S_FETCH : (op == OP_MEM) ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_op = dec_op;
        alu_funct = dec_funct;
        alu_src_imm = 1'b1;
        addr_sel = 1'b1;
        mem_read = !f;
        mem_write = f;
        retire = mem_ready && f;
        nxt = !mem_ready ? S_MEM : f ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel = op == OP_MEM;
        retire = 1'b1;
        nxt = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    if (reset) begin
      nxt = S_IDLE;
      mem_read = 1'b0;
      mem_write = 1'b0;
      addr_sel = 1'b0;
      ir_load = 1'b0;
      pc_write = 1'b0;
      pc_src = PC_INC;
      alu_op = ALUOP_ADD;
      alu_funct = 1'b0;
      alu_src_imm = 1'b0;
      reg_write = 1'b0;
      wb_sel = 1'b0;
      retire = 1'b0;
    end
  end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: per-cycle check of main_control_fsm against an instruction-recipe model
module tb_main_control_fsm;
  logic       clk = 1'b0;
  logic       reset, run, mem_ready, alu_zero;
  logic [7:0] instr;
  logic       mem_read, mem_write, addr_sel, ir_load, pc_write;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_funct, alu_src_imm, reg_write, wb_sel, halted;
  logic [7:0] retired;
  logic [14:0] dv;
  int checks = 0, errors = 0, cnt;
  logic [14:0] eq[$];
  bit          rq[$];
  logic [7:0]  erq[$];
  logic [7:0]  ret;
  typedef struct {
    logic [7:0] ins;
    int         fs;
    int         ms;
    bit         z;
    int         cyc;
    string      nm;
  } row_t;
  row_t rows[14];

  main_control_fsm #(.RETIRE_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_funct(alu_funct), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .wb_sel(wb_sel), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;
  assign dv = {mem_read, mem_write, addr_sel, ir_load, pc_write, pc_src, alu_op,
               alu_funct, alu_src_imm, reg_write, wb_sel, halted};

  function automatic logic [14:0] pk(bit mr, bit mw, bit as, bit il, bit pw, logic [1:0] ps,
                                     logic [2:0] aop, bit af, bit imm, bit rw, bit wb, bit h);
    return {mr, mw, as, il, pw, ps, aop, af, imm, rw, wb, h};
  endfunction

  function automatic bit rnd();
    return 1'($urandom);
  endfunction

  function automatic void push(logic [14:0] v, bit rdy, bit rt);
    eq.push_back(v);
    rq.push_back(rdy);
    erq.push_back(ret);
    if (rt) ret = ret + 8'd1;
  endfunction

  // expected cycle-by-cycle outputs of one instruction, built from its execution recipe
  function automatic void build(logic [7:0] ins, int fs, int ms, bit z);
    logic [2:0] op;
    bit f, imm, af;
    op = ins[7:5];
    f = ins[0];
    imm = op == 3'd4 || op == 3'd7;
    af = (op <= 3'd1) ? 1'b1 : (op == 3'd4) ? 1'b0 : f;
    for (int i = 0; i < fs; i++) push(pk(1,0,0,0,0,2'b00,3'd0,0,0,0,0,0), 1'b0, 1'b0);
    push(pk(1,0,0,1,1,2'b00,3'd0,0,0,0,0,0), 1'b1, 1'b0);
    if (op == 3'd6) begin
      push(f ? 15'd0 : pk(0,0,0,0,1,2'b10,3'd0,0,0,0,0,0), rnd(), 1'b1);
      return;
    end
    push(15'd0, rnd(), 1'b0);
    if (op == 3'd5) begin
      push(pk(0,0,0,0,z,2'b01,3'd5,f,0,0,0,0), rnd(), 1'b1);
      return;
    end
    push(pk(0,0,0,0,0,2'b00,op,af,imm,0,0,0), rnd(), 1'b0);
    if (op == 3'd7) begin
      for (int i = 0; i < ms; i++) push(pk(!f,f,1,0,0,2'b00,3'd7,f,1,0,0,0), 1'b0, 1'b0);
      push(pk(!f,f,1,0,0,2'b00,3'd7,f,1,0,0,0), 1'b1, f);
      if (f) return;
    end
    push(pk(0,0,0,0,0,2'b00,3'd0,0,0,1,op == 3'd7,0), rnd(), 1'b1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // drive the queued cycles; instr is only meaningful on the fetch-completing cycle
  task automatic apply(logic [7:0] ins, int fs, bit z, string nm, int lim);
    logic [7:0] r0;
    r0 = retired;
    cnt = 0;
    for (int i = 0; i < lim && i < eq.size(); i++) begin
      instr = (i == fs) ? ins : 8'($urandom);
      alu_zero = z;
      mem_ready = rq[i];
      run = rnd();
      @(negedge clk);
      chk({nm, " outputs"}, 32'(dv), 32'(eq[i]));
      chk({nm, " retired"}, 32'(retired), 32'(erq[i]));
      if (retired == r0) cnt++;
      @(posedge clk);
      #1;
    end
    eq.delete();
    rq.delete();
    erq.delete();
  endtask

  task automatic tick(string nm, logic [14:0] mask, logic [14:0] exp);
    @(negedge clk);
    chk(nm, 32'(dv & mask), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rows[0]  = '{8'h01, 0, 0, 1'b0, 4, "add"};
    rows[1]  = '{8'hE0, 0, 3, 1'b0, 8, "lw stall3"};
    rows[2]  = '{8'hA0, 0, 0, 1'b1, 3, "beq taken"};
    rows[3]  = '{8'hA0, 0, 0, 1'b0, 3, "beq not taken"};
    rows[4]  = '{8'hC0, 0, 0, 1'b0, 2, "jump"};
    rows[5]  = '{8'h21, 0, 0, 1'b0, 4, "nand"};
    rows[6]  = '{8'h40, 0, 0, 1'b1, 4, "slt"};
    rows[7]  = '{8'h60, 0, 0, 1'b0, 4, "shl"};
    rows[8]  = '{8'h61, 0, 0, 1'b0, 4, "shr"};
    rows[9]  = '{8'h81, 0, 0, 1'b0, 4, "addi"};
    rows[10] = '{8'hE1, 0, 0, 1'b0, 4, "sw"};
    rows[11] = '{8'hE0, 0, 0, 1'b0, 5, "lw"};
    rows[12] = '{8'h00, 2, 0, 1'b0, 6, "add fetch stall2"};
    rows[13] = '{8'hE1, 1, 2, 1'b1, 7, "sw stalls"};
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; instr = 8'h00; ret = 8'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset outputs", 32'(dv), 32'd0);
    chk("reset retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      mem_ready = rnd();
      tick("idle run=0", 15'h7fff, 15'd0);
    end
    run = 1'b1;
    tick("idle run=1", 15'h7fff, 15'd0);
    foreach (rows[k]) begin
      build(rows[k].ins, rows[k].fs, rows[k].ms, rows[k].z);
      apply(rows[k].ins, rows[k].fs, rows[k].z, rows[k].nm, 1000);
      chk({rows[k].nm, " cycles"}, 32'(cnt), 32'(rows[k].cyc));
      chk({rows[k].nm, " retire"}, 32'(retired), 32'(ret));
    end
    for (int k = 0; k < 250; k++) begin
      logic [7:0] ins;
      int fs, ms;
      bit z;
      ins = 8'($urandom);
      if (ins[7:5] == 3'd6) ins[0] = 1'b0;
      fs = $urandom_range(0, 2);
      ms = $urandom_range(0, 3);
      z = rnd();
      build(ins, fs, ms, z);
      apply(ins, fs, z, "random", 1000);
    end
    build(8'hC1, 1, 0, 1'b0);
    apply(8'hC1, 1, 1'b0, "halt", 1000);
    repeat (4) push(pk(0,0,0,0,0,2'b00,3'd0,0,0,0,0,1), rnd(), 1'b0);
    apply(8'hC1, -1, 1'b0, "halted", 1000);
    reset = 1'b1;
    tick("halt in reset strobes", 15'h7ffe, 15'd0);
    reset = 1'b0;
    run = 1'b0;
    ret = 8'd0;
    @(negedge clk);
    chk("after halt reset outputs", 32'(dv), 32'd0);
    chk("after halt reset retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    run = 1'b1;
    tick("idle before jumps", 15'h7fff, 15'd0);
    repeat (255) begin
      build(8'hC0, 0, 0, 1'b0);
      apply(8'hC0, 0, 1'b0, "jump run", 1000);
    end
    chk("255 jumps retired", 32'(retired), 32'd255);
    build(8'hC0, 0, 0, 1'b0);
    apply(8'hC0, 0, 1'b0, "jump wrap", 1000);
    chk("retired wrap", 32'(retired), 32'd0);
    build(8'hE1, 0, 5, 1'b0);
    apply(8'hE1, 0, 1'b0, "sw pre-reset", 5);
    reset = 1'b1;
    mem_ready = 1'b0;
    tick("sw in reset", 15'h7fff, 15'd0);
    reset = 1'b0;
    run = 1'b0;
    @(negedge clk);
    chk("sw after reset outputs", 32'(dv), 32'd0);
    chk("sw after reset retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    tick("idle holds", 15'h7fff, 15'd0);
    run = 1'b1;
    tick("idle sees run", 15'h7fff, 15'd0);
    tick("fetch after idle", 15'h7fff, pk(1,0,0,1,1,2'b00,3'd0,0,0,0,0,0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
